seq_shifter: RTL and testbench
==============================

SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits (legal ≥ 2).
REQ-002 SHALL have parameter AMTW, default 3, shift-amount width in bits (legal: 2**AMTW ≥ WIDTH).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request; sampled on the rising edge; accepted only when busy=0.
REQ-006 SHALL have port mode  input  3  operation select, captured at accept: 000 PASS, 001 LSL, 010 LSR, 011 ROR, 100 ROL, 101 ASR; 110/111 illegal.
REQ-007 SHALL have port amount  input  AMTW  number of 1-bit steps, captured at accept.
REQ-008 SHALL have port din  input  WIDTH  operand, captured at accept.
REQ-009 SHALL have port dout  output  WIDTH  working/result register.
REQ-010 SHALL have port carry  output  1  last bit shifted or rotated out.
REQ-011 SHALL have port busy  output  1  high while state=SHIFT.
REQ-012 SHALL have port done  output  1  one-cycle result-valid pulse.
REQ-013 SHALL have port err  output  1  illegal mode flag, valid with done.

Function
REQ-014 SHALL implement a FSM with states IDLE, SHIFT, DONE; busy=1 only in SHIFT; done=1 only in DONE.
REQ-015 Accept SHALL occur on an edge with start=1 and state IDLE or DONE: load dout←din, carry←0, capture mode, set count←amount, set err←(mode is 110/111).
REQ-016 On accept, next state SHALL be DONE if amount=0, or if mode is PASS or illegal; otherwise SHIFT.
REQ-017 In SHIFT, each edge SHALL perform exactly one 1-bit step on dout and decrement count; on the edge where count goes 1→0, next state SHALL be DONE.
REQ-018 Step definitions: LSL dout←{dout[W-2:0],0}, carry←dout[W-1]; LSR dout←{0,dout[W-1:1]}, carry←dout[0]; ASR dout←{dout[W-1],dout[W-1:1]}, carry←dout[0]; ROR dout←{dout[0],dout[W-1:1]}, carry←dout[0]; ROL dout←{dout[W-2:0],dout[W-1]}, carry←dout[W-1].
REQ-019 For accept edge E0, done SHALL be high exactly in the cycle following edge E0+N, with N=amount for shifting modes and N=0 for PASS/illegal.
REQ-020 amount ≥ WIDTH SHALL be legal and step naturally (e.g. LSL yields all zeros; ROR by WIDTH returns din).
REQ-021 PASS/illegal modes SHALL give dout=din and carry=0, regardless of amount.
REQ-022 start while busy=1 SHALL be ignored, with no effect on state, dout, carry, or count.
REQ-023 From DONE with start=0, next state SHALL be IDLE; dout, carry, and err SHALL hold until the next accept.
REQ-024 Back-to-back operation: start=1 in the DONE cycle SHALL be accepted, with no idle cycle inserted.
REQ-025 dout SHALL be guaranteed valid only while done=1 or afterwards until the next accept; intermediate values are visible during SHIFT.

Reset
REQ-026 rst_n=0 SHALL immediately, independent of clk, force state=IDLE, dout=0, carry=0, count=0, err=0, busy=0, done=0.
REQ-027 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse; the first start after rst_n rises SHALL be accepted normally.

Verification
REQ-028 LSL, din=8'b1001_0110, amount=3 -> done after E3, dout=8'b1011_0000, carry=0, busy high for 3 cycles.
REQ-029 ASR, din=8'b1000_0001, amount=2 -> done after E2, dout=8'b1110_0000, carry=0; ROR, din=8'b0000_0011, amount=1 -> dout=8'b1000_0001, carry=1.
REQ-030 LSR, din=8'hA5, amount=0 -> done after E0, dout=8'hA5, carry=0, busy never high; mode=3'b111, din=8'h3C, amount=5 -> done after E0, dout=8'h3C, err=1.
REQ-031 LSL amount=4 in progress; start pulsed with different din at E2 -> ignored, result equals din<<4; start held high in the DONE cycle -> second operation accepted immediately.
REQ-032 ROL amount=6 started, rst_n pulsed low at E3 between edges -> outputs 0 immediately, no done pulse; new ROL din=8'h81, amount=1 -> dout=8'h03, carry=1.

Source files
------------

// File: rtl/seq_shifter.sv
// Sequential barrel-free shifter: performs one 1-bit shift/rotate step per
// clock until the requested amount is exhausted, then pulses done.
module seq_shifter #(
  parameter int WIDTH = 8,
  parameter int AMTW  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [AMTW-1:0]  amount,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             carry,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [2:0] M_PASS = 3'b000;
  localparam logic [2:0] M_LSL  = 3'b001;
  localparam logic [2:0] M_LSR  = 3'b010;
  localparam logic [2:0] M_ROR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ASR  = 3'b101;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state, nxt;
  logic [2:0]      op;
  logic [AMTW-1:0] count;
  logic            accept;
  logic            illegal;
  logic            quick;

  // A new request is taken whenever we are not mid-shift (DONE included,
  // which is what allows back-to-back operation without an idle cycle).
  assign accept  = start && (state != SHIFT);
  assign illegal = mode[2] & mode[1];
  // Requests that need no stepping go straight to DONE.
  assign quick   = (amount == '0) || (mode == M_PASS) || illegal;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept) nxt = quick ? DONE : SHIFT;
      SHIFT:   if (count == AMTW'(1)) nxt = DONE;
      DONE:    if (accept) nxt = quick ? DONE : SHIFT;
               else        nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    busy = (state == SHIFT);
    done = (state == DONE);
  end

  // Datapath: capture on accept, one step per cycle while shifting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout  <= '0;
      carry <= 1'b0;
      op    <= M_PASS;
      count <= '0;
      err   <= 1'b0;
    end else if (accept) begin
      dout  <= din;
      carry <= 1'b0;
      op    <= mode;
      count <= amount;
      err   <= illegal;
    end else if (state == SHIFT) begin
      count <= count - AMTW'(1);
      case (op)
        M_LSL: begin
          dout  <= {dout[WIDTH-2:0], 1'b0};
          carry <= dout[WIDTH-1];
        end
        M_LSR: begin
          dout  <= {1'b0, dout[WIDTH-1:1]};
          carry <= dout[0];
        end
        M_ASR: begin
          dout  <= {dout[WIDTH-1], dout[WIDTH-1:1]};
          carry <= dout[0];
        end
        M_ROR: begin
          dout  <= {dout[0], dout[WIDTH-1:1]};
          carry <= dout[0];
        end
        M_ROL: begin
          dout  <= {dout[WIDTH-2:0], dout[WIDTH-1]};
          carry <= dout[WIDTH-1];
        end
        default: begin
          dout  <= dout;
          carry <= carry;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter: directed vectors plus randomized
// operations against an arithmetic reference model.
module tb_seq_shifter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] mode;
  logic [3:0] amount;
  logic [7:0] din;
  logic [7:0] dout;
  logic       carry, busy, done, err;

  int vecs = 0;
  int errs = 0;

  seq_shifter #(.WIDTH(8), .AMTW(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .amount(amount),
    .din(din), .dout(dout), .carry(carry), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Whole-operation result computed directly from shift arithmetic.
  function automatic void model(input logic [2:0] m, input logic [7:0] d,
                                input logic [3:0] n, output logic [7:0] r,
                                output logic c, output logic e, output int lat);
    int k, kk;
    k  = int'(n);
    kk = k % 8;
    e  = (m >= 3'd6);
    lat = k;
    case (m)
      3'd1: begin
        r = (k >= 8) ? 8'h00 : 8'(d << k);
        c = (k == 0) ? 1'b0 : (k <= 8) ? d[8-k] : 1'b0;
      end
      3'd2: begin
        r = (k >= 8) ? 8'h00 : 8'(d >> k);
        c = (k == 0) ? 1'b0 : (k <= 8) ? d[k-1] : 1'b0;
      end
      3'd5: begin
        r = 8'($signed(d) >>> k);
        c = (k == 0) ? 1'b0 : (k <= 8) ? d[k-1] : d[7];
      end
      3'd3: begin
        r = 8'(d >> kk) | 8'(d << (8 - kk));
        c = (k == 0) ? 1'b0 : r[7];
      end
      3'd4: begin
        r = 8'(d << kk) | 8'(d >> (8 - kk));
        c = (k == 0) ? 1'b0 : r[0];
      end
      default: begin
        r = d; c = 1'b0; lat = 0;
      end
    endcase
  endfunction

  // Issue one op (caller is at a negedge); returns at the negedge with done=1.
  // poke>=0 raises start with a junk request for one edge while shifting.
  task automatic run_op(input logic [2:0] m, input logic [7:0] d,
                        input logic [3:0] n, input int poke, input string tag);
    logic [7:0] er; logic ec, ee; int lat, j, bc;
    model(m, d, n, er, ec, ee, lat);
    start = 1'b1; mode = m; din = d; amount = n;
    @(negedge clk);
    start = 1'b0; j = 0; bc = 0;
    while (!done && j < 40) begin
      bc += int'(busy);
      if (j == poke) begin
        start = 1'b1; din = ~d; mode = 3'd1; amount = 4'd1;
      end else if (j == poke + 1) start = 1'b0;
      @(negedge clk);
      j++;
    end
    start = 1'b0;
    vecs++; if (j !== lat) begin errs++; $display("FAIL %s latency: got %0d want %0d", tag, j, lat); end
    vecs++; if (bc !== lat) begin errs++; $display("FAIL %s busy_cycles: got %0d want %0d", tag, bc, lat); end
    vecs++; if (dout !== er) begin errs++; $display("FAIL %s dout: got %h want %h", tag, dout, er); end
    vecs++; if (carry !== ec) begin errs++; $display("FAIL %s carry: got %b want %b", tag, carry, ec); end
    vecs++; if (err !== ee) begin errs++; $display("FAIL %s err: got %b want %b", tag, err, ee); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; mode = '0; amount = '0; din = '0;
    #3;
    vecs++;
    if ({dout, carry, busy, done, err} !== 12'h000) begin
      errs++; $display("FAIL reset_outputs: got %h/%b%b%b%b want 00/0000", dout, carry, busy, done, err);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_vectors();
    run_op(3'd1, 8'b1001_0110, 4'd3, -1, "lsl3");
    run_op(3'd5, 8'b1000_0001, 4'd2, -1, "asr2");
    run_op(3'd3, 8'b0000_0011, 4'd1, -1, "ror1");
    run_op(3'd2, 8'hA5, 4'd0, -1, "lsr0");
    run_op(3'd7, 8'h3C, 4'd5, -1, "illegal7");
    run_op(3'd6, 8'h5A, 4'd9, -1, "illegal6");
    run_op(3'd0, 8'hC3, 4'd7, -1, "pass7");
    run_op(3'd1, 8'hFF, 4'd8, -1, "lsl8");
    run_op(3'd3, 8'h96, 4'd8, -1, "ror8");
    run_op(3'd4, 8'h96, 4'd11, -1, "rol11");
    run_op(3'd5, 8'h80, 4'd15, -1, "asr15");
    run_op(3'd2, 8'h81, 4'd9, -1, "lsr9");
    // done is a single pulse and results hold in IDLE
    @(negedge clk);
    vecs++; if (done !== 1'b0) begin errs++; $display("FAIL done_pulse: got %b want 0", done); end
    vecs++; if (dout !== 8'h00) begin errs++; $display("FAIL hold_dout: got %h want 00", dout); end
    repeat (2) @(negedge clk);
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_busy_ignore();
    run_op(3'd1, 8'h3B, 4'd4, 1, "ignore_lsl4");
  endtask

  task automatic test_back_to_back();
    run_op(3'd1, 8'h5D, 4'd4, -1, "b2b_first");
    run_op(3'd3, 8'hE1, 4'd3, -1, "b2b_second");
    run_op(3'd0, 8'h77, 4'd2, -1, "b2b_pass");
    run_op(3'd4, 8'h12, 4'd2, -1, "b2b_rol");
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int seen;
    start = 1'b1; mode = 3'd4; din = 8'hB7; amount = 4'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    vecs++;
    if ({dout, carry, busy, done, err} !== 12'h000) begin
      errs++; $display("FAIL midreset_outputs: got %h/%b%b%b%b want 00/0000", dout, carry, busy, done, err);
    end
    #1 rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      seen += int'(done) + int'(busy);
    end
    vecs++; if (seen !== 0) begin errs++; $display("FAIL midreset_no_done: got %0d want 0", seen); end
    run_op(3'd4, 8'h81, 4'd1, -1, "post_reset_rol");
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 80; i++) begin
      run_op(3'($urandom_range(0, 7)), 8'($urandom), 4'($urandom_range(0, 15)), -1, "random");
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
